// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared state encoding, control bundle and hazard helper
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_PEND = 2'd1,
        ST_FREEZE     = 2'd2,
        ST_ILLEGAL    = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_write;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
    localparam ctrl_t CTRL_FROZEN  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                       id_ex_flush: 1'b1, ex_mem_write: 1'b0, mem_wb_write: 1'b0};

    // Forwarding cannot help a consumer directly behind a load; x0 never carries a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_ZERO) &&
               (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side bundle between the core and the hazard unit
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_uses_rs1;
    logic             ID_uses_rs2;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic             EX_branch_taken;
    logic             icache_stall;
    logic             dcache_stall;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_write;
    logic             MEM_WB_write;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] load_use_events;

    modport master (
        output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_branch_taken, icache_stall, dcache_stall,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write,
               stall_cycles, load_use_events
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_branch_taken, icache_stall, dcache_stall,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write,
               stall_cycles, load_use_events
    );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// rtl/hazard_control_unit_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/freeze sequencing for the 5-stage pipe
import hazard_control_unit_pkg::*;

module hazard_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hif
);
    state_e state_q;
    state_e state_d;
    logic   pend_q;
    logic   pend_d;
    ctrl_t  ctrl;
    logic   hazard;
    logic   lu_fire;
    logic   legal;
    logic   pending;
    logic   run_like;

    assign hazard = load_use_hazard(hif.ID_EX_MemRead, hif.ID_EX_RegisterRd, hif.ID_rs1,
                                    hif.ID_rs2, hif.ID_uses_rs1, hif.ID_uses_rs2);

    always_comb begin
        ctrl     = CTRL_DEFAULT;
        state_d  = state_q;
        pend_d   = pend_q;
        lu_fire  = 1'b0;
        legal    = 1'b1;
        pending  = 1'b0;
        run_like = 1'b0;

        // Leaving FREEZE behaves like whichever state the pipe was frozen out of.
        case (state_q)
            ST_RUN:        run_like = 1'b1;
            ST_FLUSH_PEND: pending  = 1'b1;
            ST_FREEZE: begin
                pending  = pend_q;
                run_like = !pend_q;
            end
            default: begin
                legal   = 1'b0;
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase

        if (legal) begin
            if (hif.dcache_stall) begin
                ctrl    = CTRL_FROZEN;
                state_d = ST_FREEZE;
                pend_d  = pend_q | (hif.EX_branch_taken & hif.icache_stall);
            end else if (hif.EX_branch_taken) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                pend_d           = hif.icache_stall;
                state_d          = hif.icache_stall ? ST_FLUSH_PEND : ST_RUN;
            end else if (pending) begin
                ctrl.if_id_flush = 1'b1;
                if (state_q == ST_FREEZE) begin
                    state_d = ST_FLUSH_PEND;
                end else if (!hif.icache_stall) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                end
            end else if (run_like && hazard) begin
                ctrl.pc_write    = 1'b0;
                ctrl.if_id_write = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                lu_fire          = 1'b1;
                state_d          = ST_RUN;
            end else if (run_like && hif.icache_stall) begin
                ctrl.pc_write    = 1'b0;
                ctrl.if_id_flush = 1'b1;
                state_d          = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end

        if (rst) begin
            ctrl    = CTRL_RESET;
            lu_fire = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign hif.PC_write     = ctrl.pc_write;
    assign hif.IF_ID_write  = ctrl.if_id_write;
    assign hif.IF_ID_flush  = ctrl.if_id_flush;
    assign hif.ID_EX_flush  = ctrl.id_ex_flush;
    assign hif.EX_MEM_write = ctrl.ex_mem_write;
    assign hif.MEM_WB_write = ctrl.mem_wb_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (!ctrl.pc_write && !rst),
        .count_o (hif.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (lu_fire),
        .count_o (hif.load_use_events)
    );
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam int CW = 4;
    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write}
    localparam logic [5:0] O_DEF = 6'b110011;
    localparam logic [5:0] O_RST = 6'b001100;
    localparam logic [5:0] O_FRZ = 6'b000000;
    localparam logic [5:0] O_LU  = 6'b000111;
    localparam logic [5:0] O_BR  = 6'b111111;
    localparam logic [5:0] O_FP  = 6'b111011;
    localparam logic [5:0] O_IC  = 6'b011011;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    hazard_control_unit_if #(.CNT_W(CW)) hif ();

    hazard_control_unit #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    wire [5:0] outs = {hif.PC_write, hif.IF_ID_write, hif.IF_ID_flush,
                       hif.ID_EX_flush, hif.EX_MEM_write, hif.MEM_WB_write};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hif.ID_rs1           = 5'd0;
        hif.ID_rs2           = 5'd0;
        hif.ID_uses_rs1      = 1'b0;
        hif.ID_uses_rs2      = 1'b0;
        hif.ID_EX_MemRead    = 1'b0;
        hif.ID_EX_RegisterRd = 5'd0;
        hif.EX_branch_taken  = 1'b0;
        hif.icache_stall     = 1'b0;
        hif.dcache_stall     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        #2;
        chk("reset_outs", 32'(outs), 32'(O_RST));
        chk("reset_stall", 32'(hif.stall_cycles), 0);
        chk("reset_lu", 32'(hif.load_use_events), 0);
        tick();
        rst = 1'b0;
        #3;
        chk("idle_run", 32'(outs), 32'(O_DEF));
        tick();

        // lw x5 in EX, add x6,x5,x1 in ID
        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegisterRd = 5'd5;
        hif.ID_rs1 = 5'd5; hif.ID_uses_rs1 = 1'b1; hif.ID_rs2 = 5'd1; hif.ID_uses_rs2 = 1'b1;
        #3; chk("lu_rs1_bubble", 32'(outs), 32'(O_LU));
        tick();
        clr_in();
        #3; chk("lu_after", 32'(outs), 32'(O_DEF));
        chk("lu_events_1", 32'(hif.load_use_events), 1);
        chk("lu_stall_1", 32'(hif.stall_cycles), 1);
        tick();

        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegisterRd = 5'd7;
        hif.ID_rs1 = 5'd3; hif.ID_uses_rs1 = 1'b1; hif.ID_rs2 = 5'd7; hif.ID_uses_rs2 = 1'b1;
        #3; chk("lu_rs2_bubble", 32'(outs), 32'(O_LU));
        tick();
        hif.ID_uses_rs2 = 1'b0;
        #3; chk("lu_rs2_unused", 32'(outs), 32'(O_DEF));
        tick();
        clr_in();
        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegisterRd = 5'd0;
        hif.ID_rs1 = 5'd0; hif.ID_uses_rs1 = 1'b1;
        #3; chk("lu_x0_none", 32'(outs), 32'(O_DEF));
        tick();
        #3; chk("lu_events_2", 32'(hif.load_use_events), 2);
        clr_in();

        // branch with I-cache miss: redirect + 3 flush cycles
        do_reset();
        hif.EX_branch_taken = 1'b1; hif.icache_stall = 1'b1;
        #3; chk("br_redirect", 32'(outs), 32'(O_BR));
        tick();
        hif.EX_branch_taken = 1'b0;
        #3; chk("br_pend_1", 32'(outs), 32'(O_FP));
        tick();
        #3; chk("br_pend_2", 32'(outs), 32'(O_FP));
        tick();
        hif.icache_stall = 1'b0;
        #3; chk("br_pend_exit", 32'(outs), 32'(O_FP));
        tick();
        #3; chk("br_back_run", 32'(outs), 32'(O_DEF));
        chk("br_stall_zero", 32'(hif.stall_cycles), 0);
        tick();
        hif.EX_branch_taken = 1'b1;
        #3; chk("br_hit", 32'(outs), 32'(O_BR));
        tick();
        hif.EX_branch_taken = 1'b0;
        #3; chk("br_hit_after", 32'(outs), 32'(O_DEF));

        // reset mid-FLUSH_PEND
        hif.EX_branch_taken = 1'b1; hif.icache_stall = 1'b1;
        tick();
        hif.EX_branch_taken = 1'b0;
        rst = 1'b1;
        #1; chk("rst_fp_outs", 32'(outs), 32'(O_RST));
        tick();
        rst = 1'b0;
        #3; chk("rst_fp_to_run", 32'(outs), 32'(O_IC));
        clr_in();

        // D-cache freeze with a load-use waiting in ID
        do_reset();
        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegisterRd = 5'd9;
        hif.ID_rs2 = 5'd9; hif.ID_uses_rs2 = 1'b1; hif.dcache_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3; chk($sformatf("frz_%0d", i), 32'(outs), 32'(O_FRZ));
            tick();
        end
        hif.dcache_stall = 1'b0;
        #3; chk("frz_exit_lu", 32'(outs), 32'(O_LU));
        tick();
        clr_in();
        #3; chk("frz_after", 32'(outs), 32'(O_DEF));
        chk("frz_stall_6", 32'(hif.stall_cycles), 6);
        chk("frz_lu_1", 32'(hif.load_use_events), 1);

        // D-cache stall arriving during FLUSH_PEND
        do_reset();
        hif.EX_branch_taken = 1'b1; hif.icache_stall = 1'b1;
        #3; chk("fpz_redirect", 32'(outs), 32'(O_BR));
        tick();
        hif.EX_branch_taken = 1'b0;
        #3; chk("fpz_pend", 32'(outs), 32'(O_FP));
        tick();
        hif.dcache_stall = 1'b1;
        #3; chk("fpz_frz_1", 32'(outs), 32'(O_FRZ));
        tick();
        #3; chk("fpz_frz_2", 32'(outs), 32'(O_FRZ));
        tick();
        hif.dcache_stall = 1'b0;
        #3; chk("fpz_release", 32'(outs), 32'(O_FP));
        tick();
        #3; chk("fpz_pend_again", 32'(outs), 32'(O_FP));
        tick();
        hif.icache_stall = 1'b0;
        #3; chk("fpz_pend_exit", 32'(outs), 32'(O_FP));
        tick();
        #3; chk("fpz_run", 32'(outs), 32'(O_DEF));
        chk("fpz_stall_2", 32'(hif.stall_cycles), 2);

        // I-cache only stall; saturation of the 4-bit counter
        do_reset();
        hif.icache_stall = 1'b1;
        #3; chk("ic_only", 32'(outs), 32'(O_IC));
        for (int i = 0; i < 20; i++) tick();
        #3; chk("sat_stall_F", 32'(hif.stall_cycles), 32'hF);
        chk("sat_lu_0", 32'(hif.load_use_events), 0);
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'(outs), 32'(O_RST));
        chk("async_rst_stall", 32'(hif.stall_cycles), 0);
        chk("async_rst_lu", 32'(hif.load_use_events), 0);
        tick();
        rst = 1'b0;
        clr_in();
        #3; chk("post_rst_run", 32'(outs), 32'(O_DEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Produces the pipeline control signals that the forwarding path consumes: per-stage write enables, stall bubbles and flushes.
- Sits beside the forwarding logic in the 5-stage RV32 core. Detects load-use hazards, which forwarding cannot cover.
- Sequences branch-redirect flushes across I-cache stalls and freezes the whole pipe on D-cache stalls.
- Keeps saturating performance counters for stall cycles and load-use events.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_rs1  in  5  rs1 index of the instruction in ID.
- ID_rs2  in  5  rs2 index of the instruction in ID.
- ID_uses_rs1  in  1  ID instruction reads rs1.
- ID_uses_rs2  in  1  ID instruction reads rs2.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRd  in  5  rd of the instruction in EX.
- EX_branch_taken  in  1  EX resolves a taken branch or jump; redirect PC valid this cycle.
- icache_stall  in  1  IF has no valid instruction this cycle.
- dcache_stall  in  1  MEM access is not complete.
- PC_write  out  1  PC register update enable.
- IF_ID_write  out  1  IF/ID register enable.
- IF_ID_flush  out  1  load a bubble into IF/ID.
- ID_EX_flush  out  1  load a bubble into ID/EX.
- EX_MEM_write  out  1  EX/MEM register enable.
- MEM_WB_write  out  1  MEM/WB register enable.
- stall_cycles  out  CNT_W  cycles in which PC_write was 0.
- load_use_events  out  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, pend=0, both counters 0.
  - Outputs forced: all *_write=0, IF_ID_flush=1, ID_EX_flush=1.
- Outputs are combinational from state and inputs. state, pend and the counters are registered.
- Load-use hazard is defined as: ID_EX_MemRead && ID_EX_RegisterRd!=0 && ((rd==ID_rs1 && ID_uses_rs1) || (rd==ID_rs2 && ID_uses_rs2)).
- Default outputs: all *_write=1, both flushes 0.
- Priority, evaluated in RUN and FLUSH_PEND: dcache_stall > EX_branch_taken > pending flush > load-use > icache_stall.
- dcache_stall=1:
  - All *_write=0, flushes 0.
  - Next state=FREEZE. pend keeps its value, or is set if EX_branch_taken && icache_stall.
- EX_branch_taken (no dcache_stall):
  - PC_write=1, IF_ID_flush=1, ID_EX_flush=1.
  - If icache_stall=1, next state=FLUSH_PEND and pend=1; otherwise RUN.
- FLUSH_PEND (no dcache_stall, no new branch):
  - PC_write=1, IF_ID_flush=1. ID_EX receives the IF/ID bubble naturally.
  - Stays while icache_stall=1. Returns to RUN with pend=0 the first cycle icache_stall=0; IF_ID_flush is still 1 in that cycle.
- Load-use (RUN only):
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1.
  - Exactly one bubble per event. The next cycle the load sits in MEM, the hazard term drops, and forwarding supplies the data.
  - load_use_events increments.
- icache_stall only (RUN): PC_write=0, IF_ID_flush=1, downstream stages advance.
- FREEZE:
  - All *_write=0, flushes 0 while dcache_stall=1.
  - On the first cycle with dcache_stall=0, outputs follow the RUN priority rules for that cycle. Next state=FLUSH_PEND if pend=1, else RUN.
- A branch arriving while frozen is held stable by the frozen EX stage and is handled on exit; no sticky capture is needed.
- stall_cycles increments on every cycle with PC_write=0 outside reset.
- Both counters saturate at all-ones and never wrap.
- rst asserted mid-FREEZE or mid-FLUSH_PEND returns to the RUN state immediately and clears pend.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, FLUSH_PEND=2'd1, FREEZE=2'd2; 2'd3 is illegal and recovers to RUN.
  - REG_ZERO=5'd0.
- One sub-module: sat_counter, parameterised by CNT_W, with inc input and async rst. Instantiated twice.

Test Plan:
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID with uses_rs1=1 → one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; the following cycle all defaults; load_use_events=1.
- rd=x0 load with rs1=0 in ID → no stall; load_use_events stays 0.
- Branch taken while icache_stall=1 for 3 cycles:
  - Redirect cycle plus 3 cycles with IF_ID_flush=1 and PC_write=1.
  - Return to RUN after icache_stall falls.
  - stall_cycles unchanged.
- dcache_stall for 5 cycles with a load-use pending in ID:
  - 5 cycles with all *_write=0.
  - Then one load-use bubble.
  - stall_cycles=6, load_use_events=1.
- dcache_stall rising during FLUSH_PEND → FREEZE; on release return to FLUSH_PEND and keep flushing until icache_stall=0.
- Saturation: with CNT_W=4, hold icache_stall for 20 cycles → stall_cycles=4'hF. Assert rst mid-run → all counters 0, IF_ID_flush=1 and ID_EX_flush=1 asynchronously.
